// File: rtl/leakage_char_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : leakage_char_pkg                                                |
// | Brief    : Shared types and helpers for the leakage sweep sequencer.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package leakage_char_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_APPLY   = 3'd1,
        SEQ_TRIG    = 3'd2,
        SEQ_CAPTURE = 3'd3,
        SEQ_EMIT    = 3'd4,
        SEQ_AVG     = 3'd5,
        SEQ_DONE    = 3'd6
    } seq_state_t;

    localparam int REC_STATE_W = 16;
    localparam int REC_VALUE_W = 64;

    // Record layout seen by the Liberty writer; fields sized for the widest build.
    typedef struct packed {
        logic [REC_STATE_W-1:0] state;
        logic [REC_VALUE_W-1:0] value;
        logic                   last;
        logic                   is_avg;
    } leak_rec_t;

    function automatic int unsigned NB_STATES(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/leakage_sweep_sequencer_settle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : settle_timer                                                    |
// | Brief    : Loadable saturating down-counter flagging the last settle cycle.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module settle_timer #(
    parameter int SETTLE_CYCLES = 100
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_load,
    output logic o_expired
);

    localparam int c_CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(SETTLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    // Holds the reload value during the first waited cycle, so expiry at 1 gives exactly S cycles.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign o_expired = (r_cnt <= c_ONE);

endmodule
`default_nettype wire

// File: rtl/leakage_sweep_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : leakage_sweep_sequencer                                         |
// | Brief    : Walks all input states, triggers the integrator, emits records. |
// |            Optional average record enabled by macro LEAKAGE_AVG_EN.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module leakage_sweep_sequencer
    import leakage_char_pkg::*;
#(
    parameter int NB_INPUTS     = 2,
    parameter int SETTLE_CYCLES = 100,
    parameter int MEAS_W        = 32
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NB_INPUTS-1:0] o_din,
    output logic                 o_start_measure,
    input  logic [MEAS_W-1:0]    i_measure_val,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [NB_INPUTS-1:0] o_res_state,
    output logic [MEAS_W-1:0]    o_res_value,
    output logic                 o_res_last,
    output logic                 o_res_is_avg
);

    localparam logic [2:0] c_ST_IDLE    = SEQ_IDLE;
    localparam logic [2:0] c_ST_APPLY   = SEQ_APPLY;
    localparam logic [2:0] c_ST_TRIG    = SEQ_TRIG;
    localparam logic [2:0] c_ST_CAPTURE = SEQ_CAPTURE;
    localparam logic [2:0] c_ST_EMIT    = SEQ_EMIT;
    localparam logic [2:0] c_ST_AVG     = SEQ_AVG;
    localparam logic [2:0] c_ST_DONE    = SEQ_DONE;

    localparam logic [NB_INPUTS-1:0] c_LAST_IDX = NB_INPUTS'(NB_STATES(NB_INPUTS) - 1);
    localparam logic [NB_INPUTS-1:0] c_IDX_ONE  = NB_INPUTS'(1);

    logic [2:0]           r_state;
    logic [NB_INPUTS-1:0] r_din;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_sm;
    logic                 r_res_valid;
    logic [NB_INPUTS-1:0] r_res_state;
    logic [MEAS_W-1:0]    r_res_value;
    logic                 r_res_last;
    logic                 w_expired;
    logic                 w_timer_load;

`ifdef LEAKAGE_AVG_EN
    logic [MEAS_W+NB_INPUTS-1:0] r_acc;
    logic                        r_res_is_avg;
    logic [MEAS_W-1:0]           w_avg;

    assign w_avg        = r_acc[MEAS_W+NB_INPUTS-1:NB_INPUTS];
    assign o_res_is_avg = r_res_is_avg;
`else
    assign o_res_is_avg = 1'b0;
`endif

    // One timer serves both waits: reload on every entry into APPLY or TRIG.
    assign w_timer_load = ((r_state == c_ST_IDLE)  && i_start)
                       || ((r_state == c_ST_APPLY) && w_expired)
                       || ((r_state == c_ST_EMIT)  && i_res_ready && (r_din != c_LAST_IDX));

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk       (clk),
        .nrst      (nrst),
        .i_load    (w_timer_load),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state     <= c_ST_IDLE;
            r_din       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sm        <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_state <= '0;
            r_res_value <= '0;
            r_res_last  <= 1'b0;
`ifdef LEAKAGE_AVG_EN
            r_acc        <= '0;
            r_res_is_avg <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (i_start) begin
                        r_state <= c_ST_APPLY;
                        r_din   <= '0;
                        r_busy  <= 1'b1;
`ifdef LEAKAGE_AVG_EN
                        r_acc   <= '0;
`endif
                    end
                end
                c_ST_APPLY: begin
                    if (w_expired) begin
                        r_state <= c_ST_TRIG;
                        r_sm    <= ~r_sm;
                    end
                end
                c_ST_TRIG: begin
                    if (w_expired) begin
                        r_state <= c_ST_CAPTURE;
                    end
                end
                c_ST_CAPTURE: begin
                    r_res_value <= i_measure_val;
                    r_res_state <= r_din;
                    r_res_valid <= 1'b1;
                    r_state     <= c_ST_EMIT;
`ifdef LEAKAGE_AVG_EN
                    r_acc        <= r_acc + {{NB_INPUTS{1'b0}}, i_measure_val};
                    r_res_is_avg <= 1'b0;
                    r_res_last   <= 1'b0;
`else
                    r_res_last   <= (r_din == c_LAST_IDX);
`endif
                end
                c_ST_EMIT: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_din != c_LAST_IDX) begin
                            r_din   <= r_din + c_IDX_ONE;
                            r_state <= c_ST_APPLY;
                        end else begin
`ifdef LEAKAGE_AVG_EN
                            r_state      <= c_ST_AVG;
                            r_res_valid  <= 1'b1;
                            r_res_is_avg <= 1'b1;
                            r_res_state  <= '0;
                            r_res_value  <= w_avg;
                            r_res_last   <= 1'b1;
`else
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
                c_ST_AVG: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= c_ST_DONE;
                        r_done      <= 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_din           = r_din;
    assign o_start_measure = r_sm;
    assign o_res_valid     = r_res_valid;
    assign o_res_state     = r_res_state;
    assign o_res_value     = r_res_value;
    assign o_res_last      = r_res_last;

endmodule
`default_nettype wire
